approx_mul_rr_scheduler: RTL

//  Shares one 8x8 unsigned multiplier datapath among NREQ requesters using round-robin arbitration.

---
 rtl/approx_mul_rr_scheduler_if.sv | 26 ++
 rtl/approx_mul_rr_scheduler.sv | 137 +++++++++++++
 2 files changed

// File: rtl/approx_mul_rr_scheduler_if.sv
// Request/response bus between accelerator lanes and the shared multiplier.
// The slave modport is the scheduler's view; the master modport is the lanes' view.
interface approx_mul_rr_scheduler_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [8*NREQ-1:0] req_x;
  logic [8*NREQ-1:0] req_y;
  logic [NREQ-1:0]   req_approx;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_z;
  logic [IDW-1:0]    rsp_id;

  modport slave (
    input  req_valid, req_x, req_y, req_approx, rsp_ready,
    output req_ready, rsp_valid, rsp_z, rsp_id
  );

  modport master (
    output req_valid, req_x, req_y, req_approx, rsp_ready,
    input  req_ready, rsp_valid, rsp_z, rsp_id
  );
endinterface

// File: rtl/approx_mul_rr_scheduler.sv
// Round-robin shared 8x8 multiplier (exact or l=2 approximate) with a
// two-stage pipeline: S1 holds operands, S2 holds the tagged result.
module approx_mul_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  approx_mul_rr_scheduler_if.slave     bus,
  output logic                         busy,
  output logic [15:0]                  op_count
);

  // Product of one operand pair; approximate mode drops the low partial
  // products of x[1:0] except for a few carries folded in at bits 7/8.
  function automatic logic [15:0] mul_fn(input logic [7:0] x, input logic [7:0] y,
                                         input logic approx);
    logic [7:0]  p1;
    logic [7:0]  p2;
    logic [15:0] z;
    p1 = y & {8{x[0]}};
    p2 = y & {8{x[1]}};
    if (!approx) begin
      z = {8'd0, x} * {8'd0, y};
    end else begin
      z = (({8'd0, y} * {10'd0, x[7:2]}) << 2)
        + ({15'd0, p1[6] | p2[5]} << 7)
        + ({15'd0, p2[7]} << 8)
        + ({15'd0, p1[7] & p2[6]} << 7)
        + ({15'd0, p1[7] | p2[6]} << 7);
    end
    return z;
  endfunction

  logic             adv1;
  logic             adv2;
  logic [NREQ-1:0]  grant;
  logic             grant_any;
  logic [IDW-1:0]   grant_id;
  logic [7:0]       sel_x;
  logic [7:0]       sel_y;
  logic             sel_approx;

  logic             s1_valid_q;
  logic [7:0]       s1_x_q;
  logic [7:0]       s1_y_q;
  logic             s1_approx_q;
  logic [IDW-1:0]   s1_id_q;
  logic [IDW-1:0]   last_grant_q;
  logic [IDW-1:0]   last_grant_d;
  logic             rsp_valid_q;
  logic [15:0]      rsp_z_q;
  logic [IDW-1:0]   rsp_id_q;
  logic [15:0]      op_count_q;
  logic [15:0]      op_count_d;

  assign adv2 = !rsp_valid_q | bus.rsp_ready;
  assign adv1 = !s1_valid_q | adv2;

  // Round-robin search starting just after the last granted requester;
  // nothing is granted while the pipeline cannot advance.
  always_comb begin
    int idx;
    grant      = '0;
    grant_any  = 1'b0;
    grant_id   = '0;
    sel_x      = '0;
    sel_y      = '0;
    sel_approx = 1'b0;
    idx        = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(last_grant_q) + 1 + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_any && adv1 && bus.req_valid[idx]) begin
        grant[idx] = 1'b1;
        grant_any  = 1'b1;
        grant_id   = IDW'(idx);
        sel_x      = bus.req_x[8*idx +: 8];
        sel_y      = bus.req_y[8*idx +: 8];
        sel_approx = bus.req_approx[idx];
      end
    end
  end

  // Pointer moves only on a real handshake; the counter sticks at all-ones.
  always_comb begin
    last_grant_d = grant_any ? grant_id : last_grant_q;
    op_count_d   = op_count_q;
    if (grant_any && (op_count_q != 16'hFFFF)) op_count_d = op_count_q + 16'd1;
  end

  // S1: operand capture on acceptance, bubble when advancing without a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_x_q       <= '0;
      s1_y_q       <= '0;
      s1_approx_q  <= 1'b0;
      s1_id_q      <= '0;
      last_grant_q <= IDW'(NREQ - 1);
      op_count_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      op_count_q   <= op_count_d;
      if (adv1) begin
        s1_valid_q <= grant_any;
        if (grant_any) begin
          s1_x_q      <= sel_x;
          s1_y_q      <= sel_y;
          s1_approx_q <= sel_approx;
          s1_id_q     <= grant_id;
        end
      end
    end
  end

  // S2: result register, frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_z_q     <= '0;
      rsp_id_q    <= '0;
    end else if (adv2) begin
      rsp_valid_q <= s1_valid_q;
      rsp_z_q     <= mul_fn(s1_x_q, s1_y_q, s1_approx_q);
      rsp_id_q    <= s1_id_q;
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_z     = rsp_z_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = s1_valid_q | rsp_valid_q;
  assign op_count      = op_count_q;

endmodule
